// File: rtl/tele_pkg.sv
// Shared definitions for the e-bike telemetry link: frame header bytes,
// frame length, packet and UART state encodings and a hi-byte check helper.
package tele_pkg;

    localparam logic [7:0] HDR0    = 8'hAA;
    localparam logic [7:0] HDR1    = 8'h55;
    localparam int         PKT_LEN = 8;

    typedef enum logic [3:0] {
        HUNT_AA = 4'd0,
        HUNT_55 = 4'd1,
        P0      = 4'd2,
        P1      = 4'd3,
        P2      = 4'd4,
        P3      = 4'd5,
        P4      = 4'd6,
        P5      = 4'd7
    } pkt_state_t;

    typedef enum logic [1:0] {
        UART_IDLE  = 2'd0,
        UART_START = 2'd1,
        UART_DATA  = 2'd2,
        UART_STOP  = 2'd3
    } uart_state_t;

    // A field hi byte carries only 4 significant bits; the upper nibble must be zero.
    function automatic logic hi_byte_valid(input logic [7:0] b);
        return ((b & 8'hF0) == 8'h00);
    endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first. Two-flop synchronizer preset high, start-bit
// validation at half a bit, mid-bit sampling and stop-bit checking.
// rx_idle tells the packet layer when the line is between bytes.
module uart_rx
    import tele_pkg::*;
#(
    parameter int BAUD_DIV = 2604
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RX,
    output logic [7:0] rx_data,
    output logic       byte_rdy,
    output logic       frm_err,
    output logic       rx_idle
);

    localparam logic [11:0] HALF_LAST = 12'(BAUD_DIV / 2 - 1);
    localparam logic [11:0] BIT_LAST  = 12'(BAUD_DIV - 1);

    logic        rx_meta_r;
    logic        rx_sync_r;
    logic        rx_prev_r;
    logic        fall_s;
    uart_state_t state_r;
    logic [11:0] baud_cnt_r;
    logic [2:0]  bit_cnt_r;
    logic [7:0]  shift_r;
    logic [7:0]  rx_data_r;
    logic        byte_rdy_r;
    logic        frm_err_r;

    // Bring the asynchronous line into the clock domain and keep one extra sample for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
            rx_prev_r <= 1'b1;
        end else begin
            rx_meta_r <= RX;
            rx_sync_r <= rx_meta_r;
            rx_prev_r <= rx_sync_r;
        end
    end

    assign fall_s = rx_prev_r & ~rx_sync_r;

    // Byte framing state machine with baud counter, bit counter and shifter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= UART_IDLE;
            baud_cnt_r <= 12'd0;
            bit_cnt_r  <= 3'd0;
            shift_r    <= 8'd0;
            rx_data_r  <= 8'd0;
            byte_rdy_r <= 1'b0;
            frm_err_r  <= 1'b0;
        end else begin
            byte_rdy_r <= 1'b0;
            frm_err_r  <= 1'b0;
            case (state_r)
                UART_IDLE: begin
                    baud_cnt_r <= 12'd0;
                    bit_cnt_r  <= 3'd0;
                    if (fall_s) begin
                        state_r <= UART_START;
                    end else begin
                        state_r <= UART_IDLE;
                    end
                end
                UART_START: begin
                    if (baud_cnt_r == HALF_LAST) begin
                        baud_cnt_r <= 12'd0;
                        // A line already back high at mid start bit was only a glitch.
                        if (rx_sync_r) begin
                            state_r <= UART_IDLE;
                        end else begin
                            state_r <= UART_DATA;
                        end
                    end else begin
                        baud_cnt_r <= baud_cnt_r + 12'd1;
                    end
                end
                UART_DATA: begin
                    if (baud_cnt_r == BIT_LAST) begin
                        baud_cnt_r <= 12'd0;
                        shift_r    <= {rx_sync_r, shift_r[7:1]};
                        if (bit_cnt_r == 3'd7) begin
                            bit_cnt_r <= 3'd0;
                            state_r   <= UART_STOP;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 3'd1;
                        end
                    end else begin
                        baud_cnt_r <= baud_cnt_r + 12'd1;
                    end
                end
                UART_STOP: begin
                    if (baud_cnt_r == BIT_LAST) begin
                        baud_cnt_r <= 12'd0;
                        state_r    <= UART_IDLE;
                        if (rx_sync_r) begin
                            rx_data_r  <= shift_r;
                            byte_rdy_r <= 1'b1;
                        end else begin
                            frm_err_r  <= 1'b1;
                        end
                    end else begin
                        baud_cnt_r <= baud_cnt_r + 12'd1;
                    end
                end
                default: begin
                    state_r    <= UART_IDLE;
                    baud_cnt_r <= 12'd0;
                    bit_cnt_r  <= 3'd0;
                end
            endcase
        end
    end

    assign rx_data  = rx_data_r;
    assign byte_rdy = byte_rdy_r;
    assign frm_err  = frm_err_r;
    assign rx_idle  = (state_r == UART_IDLE);

endmodule

// File: rtl/telemetry_rx.sv
// Telemetry link receiver: finds the AA 55 framed 8-byte packet in the UART
// byte stream, checks hi-byte nibbles, guards against inter-byte stalls and
// publishes the three 12-bit fields atomically with a one-cycle valid strobe.
module telemetry_rx
    import tele_pkg::*;
#(
    parameter int BAUD_DIV = 2604,
    parameter int GAP_BITS = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX,
    output logic [11:0] batt_v,
    output logic [11:0] avg_curr,
    output logic [11:0] avg_torque,
    output logic        pkt_vld,
    output logic        pkt_err
);

    localparam int GAP_LIMIT = GAP_BITS * BAUD_DIV;
    localparam int GAP_W     = $clog2(GAP_LIMIT + 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_LIMIT - 1);

    logic [7:0]       rx_data_s;
    logic             byte_rdy_s;
    logic             frm_err_s;
    logic             rx_idle_s;
    logic             timeout_s;
    pkt_state_t       state_r;
    logic [GAP_W-1:0] gap_cnt_r;
    logic [3:0]       batt_hi_r;
    logic [7:0]       batt_lo_r;
    logic [3:0]       curr_hi_r;
    logic [7:0]       curr_lo_r;
    logic [3:0]       torq_hi_r;
    logic [11:0]      batt_v_r;
    logic [11:0]      avg_curr_r;
    logic [11:0]      avg_torque_r;
    logic             pkt_vld_r;
    logic             pkt_err_r;

    uart_rx #(
        .BAUD_DIV (BAUD_DIV)
    ) u_uart_rx (
        .clk      (clk),
        .rst_n    (rst_n),
        .RX       (RX),
        .rx_data  (rx_data_s),
        .byte_rdy (byte_rdy_s),
        .frm_err  (frm_err_s),
        .rx_idle  (rx_idle_s)
    );

    // A byte arriving on the expiry cycle wins; the gap is only measured once a packet has started.
    assign timeout_s = (state_r != HUNT_AA) && rx_idle_s && !byte_rdy_s && (gap_cnt_r == GAP_LAST);

    // Inter-byte gap counter: counts idle line time inside a packet, cleared by any byte or abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gap_cnt_r <= '0;
        end else begin
            if ((state_r == HUNT_AA) || byte_rdy_s || frm_err_s || timeout_s) begin
                gap_cnt_r <= '0;
            end else if (rx_idle_s) begin
                gap_cnt_r <= gap_cnt_r + GAP_W'(1);
            end else begin
                gap_cnt_r <= gap_cnt_r;
            end
        end
    end

    // Packet FSM, shadow buffer and output registers; outputs only move on a complete good packet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= HUNT_AA;
            batt_hi_r    <= 4'd0;
            batt_lo_r    <= 8'd0;
            curr_hi_r    <= 4'd0;
            curr_lo_r    <= 8'd0;
            torq_hi_r    <= 4'd0;
            batt_v_r     <= 12'd0;
            avg_curr_r   <= 12'd0;
            avg_torque_r <= 12'd0;
            pkt_vld_r    <= 1'b0;
            pkt_err_r    <= 1'b0;
        end else begin
            pkt_vld_r <= 1'b0;
            pkt_err_r <= 1'b0;
            // Framing error and timeout share one abort path so a coincidence gives a single pulse.
            if (frm_err_s || timeout_s) begin
                pkt_err_r <= 1'b1;
                state_r   <= HUNT_AA;
            end else if (byte_rdy_s) begin
                case (state_r)
                    HUNT_AA: begin
                        if (rx_data_s == HDR0) begin
                            state_r <= HUNT_55;
                        end else begin
                            state_r <= HUNT_AA;
                        end
                    end
                    HUNT_55: begin
                        if (rx_data_s == HDR1) begin
                            state_r <= P0;
                        end else if (rx_data_s == HDR0) begin
                            state_r <= HUNT_55;
                        end else begin
                            state_r <= HUNT_AA;
                        end
                    end
                    P0: begin
                        if (hi_byte_valid(rx_data_s)) begin
                            batt_hi_r <= rx_data_s[3:0];
                            state_r   <= P1;
                        end else begin
                            pkt_err_r <= 1'b1;
                            state_r   <= HUNT_AA;
                        end
                    end
                    P1: begin
                        batt_lo_r <= rx_data_s;
                        state_r   <= P2;
                    end
                    P2: begin
                        if (hi_byte_valid(rx_data_s)) begin
                            curr_hi_r <= rx_data_s[3:0];
                            state_r   <= P3;
                        end else begin
                            pkt_err_r <= 1'b1;
                            state_r   <= HUNT_AA;
                        end
                    end
                    P3: begin
                        curr_lo_r <= rx_data_s;
                        state_r   <= P4;
                    end
                    P4: begin
                        if (hi_byte_valid(rx_data_s)) begin
                            torq_hi_r <= rx_data_s[3:0];
                            state_r   <= P5;
                        end else begin
                            pkt_err_r <= 1'b1;
                            state_r   <= HUNT_AA;
                        end
                    end
                    P5: begin
                        batt_v_r     <= {batt_hi_r, batt_lo_r};
                        avg_curr_r   <= {curr_hi_r, curr_lo_r};
                        avg_torque_r <= {torq_hi_r, rx_data_s};
                        pkt_vld_r    <= 1'b1;
                        state_r      <= HUNT_AA;
                    end
                    default: begin
                        state_r <= HUNT_AA;
                    end
                endcase
            end else begin
                state_r <= state_r;
            end
        end
    end

    assign batt_v     = batt_v_r;
    assign avg_curr   = avg_curr_r;
    assign avg_torque = avg_torque_r;
    assign pkt_vld    = pkt_vld_r;
    assign pkt_err    = pkt_err_r;

endmodule

// File: tb/tb_telemetry_rx.sv
// Self-checking bench for telemetry_rx: table of packet streams plus hand-written
// corner sequences (glitch, stall timeout, reset mid-packet); good packets are
// scoreboarded through a queue of expected field triples.
module tb_telemetry_rx;
    import tele_pkg::*;

    localparam int BAUD = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        RX = 1'b1;
    logic [11:0] batt_v;
    logic [11:0] avg_curr;
    logic [11:0] avg_torque;
    logic        pkt_vld;
    logic        pkt_err;

    int n_checks = 0;
    int n_fail   = 0;
    int vld_cnt  = 0;
    int err_cnt  = 0;
    logic [35:0] exp_q[$];
    logic [35:0] sb_exp;

    typedef struct {
        int                 len;
        logic [0:12][7:0]   b;
        int                 bad_idx;
        int                 idle_after;
        int                 exp_vld;
        int                 exp_err;
        logic [35:0]        fields;
    } vec_t;

    vec_t vecs[7];

    telemetry_rx #(
        .BAUD_DIV (BAUD),
        .GAP_BITS (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .RX         (RX),
        .batt_v     (batt_v),
        .avg_curr   (avg_curr),
        .avg_torque (avg_torque),
        .pkt_vld    (pkt_vld),
        .pkt_err    (pkt_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic v);
        RX = v;
        repeat (BAUD) @(posedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic bad_stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(~bad_stop);
        RX = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    // Output monitor: counts pulses and pops the scoreboard on every pkt_vld.
    always @(negedge clk) begin
        if (rst_n) begin
            if (pkt_vld || pkt_err) check("vld_err_exclusive", {35'd0, pkt_vld & pkt_err}, 36'd0);
            if (pkt_vld) begin
                vld_cnt++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_vld: got fields %h, expected no packet", {batt_v, avg_curr, avg_torque});
                end else begin
                    sb_exp = exp_q.pop_front();
                    check("scoreboard_fields", {batt_v, avg_curr, avg_torque}, sb_exp);
                end
            end
            if (pkt_err) err_cnt++;
        end
    end

    initial begin
        int v0;
        int e0;

        vecs[0] = '{8,  {HDR0, HDR1, 8'h0A, 8'h98, 8'h01, 8'h23, 8'h04, 8'h56, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, -1, 0,  1, 0, {12'hA98, 12'h123, 12'h456}};
        vecs[1] = '{8,  {HDR0, HDR1, 8'h0F, 8'hFF, 8'h00, 8'h00, 8'h0F, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, -1, 64, 1, 0, {12'hFFF, 12'h000, 12'hFFF}};
        vecs[2] = '{11, {8'h12, 8'h34, HDR0, HDR0, HDR1, 8'h01, 8'h11, 8'h02, 8'h22, 8'h03, 8'h33, 8'h00, 8'h00}, -1, 64, 1, 0, {12'h111, 12'h222, 12'h333}};
        vecs[3] = '{8,  {HDR0, HDR1, 8'h1A, 8'h98, 8'h01, 8'h23, 8'h04, 8'h56, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, -1, 64, 0, 1, {12'h111, 12'h222, 12'h333}};
        vecs[4] = '{8,  {HDR0, HDR1, 8'h07, 8'h65, 8'h04, 8'h32, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, -1, 64, 1, 0, {12'h765, 12'h432, 12'h100}};
        vecs[5] = '{6,  {HDR0, HDR1, 8'h0A, 8'h98, 8'h01, 8'h23, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 5,  64, 0, 1, {12'h765, 12'h432, 12'h100}};
        vecs[6] = '{8,  {HDR0, HDR1, 8'h0C, 8'hDE, 8'h0B, 8'hAD, 8'h0F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, -1, 64, 1, 0, {12'hCDE, 12'hBAD, 12'hF00}};

        // Reset state
        idle(5);
        @(negedge clk);
        check("reset_fields", {batt_v, avg_curr, avg_torque}, 36'd0);
        check("reset_pulses", {34'd0, pkt_vld, pkt_err}, 36'd0);
        rst_n = 1'b1;
        idle(20);

        // Table-driven packet streams
        for (int i = 0; i < 7; i++) begin
            v0 = vld_cnt;
            e0 = err_cnt;
            if (vecs[i].exp_vld != 0) exp_q.push_back(vecs[i].fields);
            for (int k = 0; k < vecs[i].len; k++) send_byte(vecs[i].b[k], k == vecs[i].bad_idx);
            idle(vecs[i].idle_after);
            @(negedge clk);
            check($sformatf("vec%0d_vld_count", i), 36'(vld_cnt - v0), 36'(vecs[i].exp_vld));
            check($sformatf("vec%0d_err_count", i), 36'(err_cnt - e0), 36'(vecs[i].exp_err));
            check($sformatf("vec%0d_fields", i), {batt_v, avg_curr, avg_torque}, vecs[i].fields);
        end

        // Short low glitch on idle line inside a packet must not produce a byte
        v0 = vld_cnt;
        e0 = err_cnt;
        send_byte(HDR0, 1'b0);
        send_byte(HDR1, 1'b0);
        RX = 1'b0;
        idle(4);
        RX = 1'b1;
        idle(40);
        @(negedge clk);
        check("glitch_no_err", 36'(err_cnt - e0), 36'd0);
        exp_q.push_back({12'hA98, 12'h123, 12'h456});
        send_byte(8'h0A, 1'b0);
        send_byte(8'h98, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h23, 1'b0);
        send_byte(8'h04, 1'b0);
        send_byte(8'h56, 1'b0);
        idle(64);
        @(negedge clk);
        check("glitch_pkt_vld", 36'(vld_cnt - v0), 36'd1);
        check("glitch_pkt_err", 36'(err_cnt - e0), 36'd0);

        // Stall after P2 -> timeout, then FSM must be hunting
        v0 = vld_cnt;
        e0 = err_cnt;
        send_byte(HDR0, 1'b0);
        send_byte(HDR1, 1'b0);
        send_byte(8'h0A, 1'b0);
        send_byte(8'h98, 1'b0);
        send_byte(8'h01, 1'b0);
        idle(300);
        @(negedge clk);
        check("stall_err", 36'(err_cnt - e0), 36'd1);
        check("stall_no_vld", 36'(vld_cnt - v0), 36'd0);
        check("stall_hold", {batt_v, avg_curr, avg_torque}, {12'hA98, 12'h123, 12'h456});
        e0 = err_cnt;
        send_byte(8'h23, 1'b0);
        send_byte(8'h04, 1'b0);
        send_byte(8'h56, 1'b0);
        idle(64);
        @(negedge clk);
        check("stall_tail_no_vld", 36'(vld_cnt - v0), 36'd0);
        check("stall_tail_no_err", 36'(err_cnt - e0), 36'd0);

        // Reset asserted during byte P4
        send_byte(HDR0, 1'b0);
        send_byte(HDR1, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h22, 1'b0);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b0);
        RX = 1'b0;
        idle(6);
        rst_n = 1'b0;
        idle(3);
        RX = 1'b1;
        idle(2);
        rst_n = 1'b1;
        @(negedge clk);
        check("midreset_fields", {batt_v, avg_curr, avg_torque}, 36'd0);
        check("midreset_pulses", {34'd0, pkt_vld, pkt_err}, 36'd0);
        idle(32);
        v0 = vld_cnt;
        e0 = err_cnt;
        send_byte(8'h0C, 1'b0);
        send_byte(8'hDE, 1'b0);
        send_byte(8'h0B, 1'b0);
        send_byte(8'hAD, 1'b0);
        send_byte(8'h0F, 1'b0);
        send_byte(8'h00, 1'b0);
        idle(64);
        @(negedge clk);
        check("headerless_no_vld", 36'(vld_cnt - v0), 36'd0);
        check("headerless_no_err", 36'(err_cnt - e0), 36'd0);
        check("headerless_fields", {batt_v, avg_curr, avg_torque}, 36'd0);
        exp_q.push_back({12'h321, 12'h654, 12'h987});
        send_byte(HDR0, 1'b0);
        send_byte(HDR1, 1'b0);
        send_byte(8'h03, 1'b0);
        send_byte(8'h21, 1'b0);
        send_byte(8'h06, 1'b0);
        send_byte(8'h54, 1'b0);
        send_byte(8'h09, 1'b0);
        send_byte(8'h87, 1'b0);
        idle(64);
        @(negedge clk);
        check("postreset_vld", 36'(vld_cnt - v0), 36'd1);
        check("postreset_err", 36'(err_cnt - e0), 36'd0);
        check("postreset_fields", {batt_v, avg_curr, avg_torque}, {12'h321, 12'h654, 12'h987});

        check("scoreboard_drained", 36'(exp_q.size()), 36'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
